cpu_sequential_core: RTL and testbench

Single-cycle (one instruction per clock) RV64 integer core implementing the subset add, sub, and, or, addi, ld, sd and beq.
- Contains internal instruction memory, a 32x64 register file, data memory, ALU, main control and a PC register.
- Top-level processor block; the bench preloads the instruction memory array and probes internal state hierarchically.
- An all-zero instruction word is the halt marker.

---
 rtl/cpu_sequential_core.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_cpu_sequential_core.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequential_core.sv
// Single-cycle RV64 integer core: add, sub, and, or, addi, ld, sd, beq.
// One instruction per clock; an all-zero instruction word halts the core.

package cpu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

endpackage

// Instruction ROM; contents are loaded from outside, never by reset.
module cpu_imem #(
  parameter int DEPTH = 64
) (
  input  logic [63:0] addr,
  output logic [31:0] instruction
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] memory [DEPTH];
  logic        unused_low;

  assign unused_low = ^addr[1:0];

  // Fetch; anything past the array reads as the halt word.
  always_comb begin
    instruction = '0;
    if (addr[63:AW+2] == '0) begin
      instruction = memory[addr[AW+1:2]];
    end
  end

endmodule

// Doubleword data memory; address wraps modulo DEPTH.
module cpu_dmem #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] addr,
  input  logic [63:0] write_data,
  output logic [63:0] read_data
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   memory [DEPTH];
  logic [AW-1:0] index;
  logic          unused_bits;

  assign index       = addr[AW+2:3];
  assign unused_bits = ^{addr[63:AW+3], addr[2:0]};

  // Store port; reset clears every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        memory[i] <= '0;
      end
    end else if (mem_write) begin
      memory[index] <= write_data;
    end
  end

  // Combinational load port.
  always_comb begin
    read_data = '0;
    if (mem_read) begin
      read_data = memory[index];
    end
  end

endmodule

// 32 x 64 register file; x0 is hardwired to zero.
module cpu_reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        write_en,
  input  logic [63:0] write_data,
  output logic [63:0] read_data1,
  output logic [63:0] read_data2
);

  logic [63:0] registers [32];

  // Write port; x0 writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= '0;
      end
    end else if (write_en && (rd != 5'd0)) begin
      registers[rd] <= write_data;
    end
  end

  // Read ports see the pre-edge value.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (rs1 != 5'd0) read_data1 = registers[rs1];
    if (rs2 != 5'd0) read_data2 = registers[rs2];
  end

endmodule

// 64-bit ALU with zero flag for beq.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_op_t     op,
  output logic [63:0] result,
  output logic        zero
);

  // Operation select.
  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// Main decoder; unknown encodings fall through as NOPs.
module cpu_control
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_to_reg,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output alu_op_t    alu_op
);

  logic is_r;
  logic is_addi;
  logic is_ld;
  logic is_sd;
  logic is_beq;

  assign is_r    = (opcode == 7'b0110011);
  assign is_addi = (opcode == 7'b0010011);
  assign is_ld   = (opcode == 7'b0000011);
  assign is_sd   = (opcode == 7'b0100011);
  assign is_beq  = (opcode == 7'b1100011);

  // Control word per instruction class.
  always_comb begin
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = ALU_ADD;
    unique case (1'b1)
      is_r: begin
        unique case (funct3)
          3'b000: begin
            reg_write = 1'b1;
            alu_op    = funct7b5 ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin
            reg_write = 1'b1;
            alu_op    = ALU_AND;
          end
          3'b110: begin
            reg_write = 1'b1;
            alu_op    = ALU_OR;
          end
          default: ;
        endcase
      end
      is_addi: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      is_ld: begin
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      is_sd: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      is_beq: begin
        branch = 1'b1;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// Top level: PC register plus the single-cycle datapath.
module cpu_sequential_core
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc,
  output logic        halted
);

  logic [63:0] pc_current;
  logic [63:0] pc_next;
  logic [31:0] instruction;

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] imm_b;

  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  alu_op_t     alu_op;

  logic [63:0] reg_read_data1;
  logic [63:0] reg_read_data2;
  logic [63:0] alu_b;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic [63:0] mem_read_data;
  logic [63:0] reg_write_data;

  assign pc     = pc_current;
  assign halted = (instruction == 32'h0);

  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
  assign rd  = instruction[11:7];

  assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{52{instruction[31]}}, instruction[31:25],
                  instruction[11:7]};
  assign imm_b = {{51{instruction[31]}}, instruction[31],
                  instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};

  cpu_imem #(
    .DEPTH(IMEM_DEPTH)
  ) imem (
    .addr        (pc_current),
    .instruction (instruction)
  );

  cpu_control ctrl (
    .opcode     (instruction[6:0]),
    .funct3     (instruction[14:12]),
    .funct7b5   (instruction[30]),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .alu_op     (alu_op)
  );

  cpu_reg_file reg_file (
    .clk        (clk),
    .rst_n      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .write_en   (reg_write),
    .write_data (reg_write_data),
    .read_data1 (reg_read_data1),
    .read_data2 (reg_read_data2)
  );

  assign alu_b = !alu_src  ? reg_read_data2 :
                 mem_write ? imm_s : imm_i;

  cpu_alu alu (
    .a      (reg_read_data1),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  cpu_dmem #(
    .DEPTH(DMEM_DEPTH)
  ) dmem (
    .clk        (clk),
    .rst_n      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (alu_result),
    .write_data (reg_read_data2),
    .read_data  (mem_read_data)
  );

  assign reg_write_data = mem_to_reg ? mem_read_data : alu_result;

  // Next PC: hold on halt, take beq when operands match.
  always_comb begin
    pc_next = pc_current + 64'd4;
    if (halted) begin
      pc_next = pc_current;
    end else if (branch && alu_zero) begin
      pc_next = pc_current + imm_b;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_current <= '0;
    end else begin
      pc_current <= pc_next;
    end
  end

endmodule

// File: tb/tb_cpu_sequential_core.sv
// Directed bench for cpu_sequential_core.
// Programs are poked into imem; state is probed hierarchically.

module tb_cpu_sequential_core;

  logic        clk;
  logic        reset;
  logic [63:0] pc;
  logic        halted;

  int tests;
  int fails;

  logic [31:0] prog [64];

  cpu_sequential_core dut (
    .clk    (clk),
    .reset  (reset),
    .pc     (pc),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input logic [4:0] rd,
    input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] ld(input logic [4:0] rd,
    input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b011, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sd(input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000,
            off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
  endtask

  // Hold reset, load the program, release between edges.
  task automatic boot();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) dut.imem.memory[i] = prog[i];
    #1;
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int nz;
    clear_prog();
    prog[0] = addi(5'd1, 5'd0, 12'd1);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) dut.imem.memory[i] = prog[i];
    #1;
    tests++;
    if (pc !== 64'd0) begin
      fails++; $display("FAIL reset_pc got %0h want 0", pc);
    end
    tests++;
    if (halted !== 1'b0) begin
      fails++; $display("FAIL reset_halted_lo got %0b want 0", halted);
    end
    nz = 0;
    for (int i = 0; i < 32; i++)
      if (dut.reg_file.registers[i] !== 64'd0) nz++;
    for (int i = 0; i < 32; i++)
      if (dut.dmem.memory[i] !== 64'd0) nz++;
    tests++;
    if (nz !== 0) begin
      fails++; $display("FAIL reset_state nonzero words %0d want 0", nz);
    end
    dut.imem.memory[0] = 32'h0;
    #1;
    tests++;
    if (halted !== 1'b1) begin
      fails++; $display("FAIL reset_halted_hi got %0b want 1", halted);
    end
  endtask

  task automatic test_program();
    int nz;
    clear_prog();
    prog[0] = 32'h00A00393;
    prog[1] = 32'h01400413;
    prog[2] = 32'h00702023;
    prog[3] = 32'h00802423;
    boot();
    step(4);
    tests++;
    if (pc !== 64'd16 || halted !== 1'b1) begin
      fails++;
      $display("FAIL prog_halt pc=%0d halted=%0b want 16/1", pc, halted);
    end
    tests++;
    if (dut.reg_file.registers[7] !== 64'd10 ||
        dut.reg_file.registers[8] !== 64'd20) begin
      fails++;
      $display("FAIL prog_regs x7=%0d x8=%0d want 10/20",
               dut.reg_file.registers[7], dut.reg_file.registers[8]);
    end
    tests++;
    if (dut.dmem.memory[0] !== 64'd10 || dut.dmem.memory[1] !== 64'd20) begin
      fails++;
      $display("FAIL prog_dmem m0=%0d m1=%0d want 10/20",
               dut.dmem.memory[0], dut.dmem.memory[1]);
    end
    nz = 0;
    for (int i = 0; i < 32; i++)
      if (i != 7 && i != 8 && dut.reg_file.registers[i] !== 64'd0) nz++;
    for (int i = 2; i < 32; i++)
      if (dut.dmem.memory[i] !== 64'd0) nz++;
    tests++;
    if (nz !== 0) begin
      fails++; $display("FAIL prog_others nonzero %0d want 0", nz);
    end
    step(3);
    tests++;
    if (pc !== 64'd16 || halted !== 1'b1) begin
      fails++;
      $display("FAIL prog_hold pc=%0d halted=%0b want 16/1", pc, halted);
    end
  endtask

  task automatic test_alu();
    clear_prog();
    prog[0] = addi(5'd1, 5'd0, 12'd12);
    prog[1] = addi(5'd2, 5'd0, 12'd10);
    prog[2] = rtype(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2);
    prog[3] = rtype(7'b0100000, 3'b000, 5'd4, 5'd2, 5'd1);
    prog[4] = rtype(7'b0000000, 3'b111, 5'd5, 5'd1, 5'd2);
    prog[5] = rtype(7'b0000000, 3'b110, 5'd6, 5'd1, 5'd2);
    prog[6] = addi(5'd7, 5'd0, 12'hFFD);
    boot();
    step(7);
    tests++;
    if (dut.reg_file.registers[3] !== 64'd22) begin
      fails++;
      $display("FAIL alu_add got %0d want 22", dut.reg_file.registers[3]);
    end
    tests++;
    if (dut.reg_file.registers[4] !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      fails++;
      $display("FAIL alu_sub got %h want fffffffffffffffe",
               dut.reg_file.registers[4]);
    end
    tests++;
    if (dut.reg_file.registers[5] !== 64'd8) begin
      fails++;
      $display("FAIL alu_and got %0d want 8", dut.reg_file.registers[5]);
    end
    tests++;
    if (dut.reg_file.registers[6] !== 64'd14) begin
      fails++;
      $display("FAIL alu_or got %0d want 14", dut.reg_file.registers[6]);
    end
    tests++;
    if (dut.reg_file.registers[7] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      fails++;
      $display("FAIL alu_addi_neg got %h want fffffffffffffffd",
               dut.reg_file.registers[7]);
    end
    tests++;
    if (pc !== 64'd28 || halted !== 1'b1) begin
      fails++;
      $display("FAIL alu_pc pc=%0d halted=%0b want 28/1", pc, halted);
    end
  endtask

  task automatic test_load_x0();
    clear_prog();
    prog[0] = addi(5'd7, 5'd0, 12'd10);
    prog[1] = sd(5'd7, 5'd0, 12'd16);
    prog[2] = ld(5'd9, 5'd0, 12'd16);
    prog[3] = addi(5'd0, 5'd0, 12'd5);
    prog[4] = sd(5'd7, 5'd0, 12'd280);
    prog[5] = ld(5'd11, 5'd0, 12'd24);
    prog[6] = ld(5'd12, 5'd0, 12'd19);
    boot();
    step(7);
    tests++;
    if (dut.reg_file.registers[9] !== 64'd10) begin
      fails++;
      $display("FAIL ld_x9 got %0d want 10", dut.reg_file.registers[9]);
    end
    tests++;
    if (dut.reg_file.registers[0] !== 64'd0) begin
      fails++;
      $display("FAIL x0_write got %0d want 0", dut.reg_file.registers[0]);
    end
    tests++;
    if (dut.dmem.memory[3] !== 64'd10 || dut.dmem.memory[2] !== 64'd10) begin
      fails++;
      $display("FAIL sd_wrap m2=%0d m3=%0d want 10/10",
               dut.dmem.memory[2], dut.dmem.memory[3]);
    end
    tests++;
    if (dut.reg_file.registers[11] !== 64'd10) begin
      fails++;
      $display("FAIL ld_wrap got %0d want 10", dut.reg_file.registers[11]);
    end
    tests++;
    if (dut.reg_file.registers[12] !== 64'd10) begin
      fails++;
      $display("FAIL ld_unaligned got %0d want 10",
               dut.reg_file.registers[12]);
    end
    tests++;
    if (pc !== 64'd28) begin
      fails++; $display("FAIL ld_pc got %0d want 28", pc);
    end
  endtask

  task automatic test_branch(input logic [11:0] b_val,
                             input logic taken);
    clear_prog();
    prog[0] = addi(5'd1, 5'd0, 12'd5);
    prog[1] = addi(5'd2, 5'd0, b_val);
    for (int i = 2; i < 8; i++) prog[i] = 32'h00000013;
    prog[8]  = beq(5'd1, 5'd2, 13'd8);
    prog[9]  = addi(5'd3, 5'd0, 12'd1);
    prog[10] = addi(5'd4, 5'd0, 12'd2);
    boot();
    step(8);
    tests++;
    if (pc !== 64'h20) begin
      fails++; $display("FAIL beq_at got %0h want 20", pc);
    end
    step(1);
    tests++;
    if (pc !== (taken ? 64'h28 : 64'h24)) begin
      fails++;
      $display("FAIL beq_target taken=%0b got %0h want %0h",
               taken, pc, taken ? 64'h28 : 64'h24);
    end
    step(3);
    tests++;
    if (dut.reg_file.registers[3] !== (taken ? 64'd0 : 64'd1) ||
        dut.reg_file.registers[4] !== 64'd2) begin
      fails++;
      $display("FAIL beq_effect taken=%0b x3=%0d x4=%0d",
               taken, dut.reg_file.registers[3],
               dut.reg_file.registers[4]);
    end
    tests++;
    if (pc !== 64'h2C || halted !== 1'b1) begin
      fails++;
      $display("FAIL beq_end pc=%0h halted=%0b want 2c/1", pc, halted);
    end
  endtask

  task automatic test_branch_loops();
    clear_prog();
    prog[0] = 32'h00000013;
    prog[1] = beq(5'd0, 5'd0, 13'd0);
    boot();
    step(2);
    tests++;
    if (pc !== 64'd4) begin
      fails++; $display("FAIL self_loop_a got %0d want 4", pc);
    end
    step(5);
    tests++;
    if (pc !== 64'd4 || halted !== 1'b0) begin
      fails++;
      $display("FAIL self_loop_b pc=%0d halted=%0b want 4/0", pc, halted);
    end
    clear_prog();
    prog[0] = addi(5'd5, 5'd5, 12'd1);
    prog[1] = beq(5'd0, 5'd0, 13'h1FFC);
    boot();
    step(6);
    tests++;
    if (pc !== 64'd0 || dut.reg_file.registers[5] !== 64'd3) begin
      fails++;
      $display("FAIL back_loop pc=%0d x5=%0d want 0/3",
               pc, dut.reg_file.registers[5]);
    end
    clear_prog();
    prog[0] = beq(5'd0, 5'd0, 13'd256);
    boot();
    step(1);
    tests++;
    if (pc !== 64'd256 || halted !== 1'b1) begin
      fails++;
      $display("FAIL beyond_imem pc=%0d halted=%0b want 256/1",
               pc, halted);
    end
    step(2);
    tests++;
    if (pc !== 64'd256) begin
      fails++; $display("FAIL beyond_hold got %0d want 256", pc);
    end
  endtask

  task automatic test_reset_mid();
    clear_prog();
    prog[0] = addi(5'd2, 5'd0, 12'd9);
    prog[1] = sd(5'd2, 5'd0, 12'd0);
    for (int i = 2; i < 10; i++) prog[i] = addi(5'd1, 5'd1, 12'd1);
    boot();
    step(4);
    tests++;
    if (pc !== 64'd16 || dut.reg_file.registers[1] !== 64'd2 ||
        dut.dmem.memory[0] !== 64'd9) begin
      fails++;
      $display("FAIL mid_before pc=%0d x1=%0d m0=%0d want 16/2/9",
               pc, dut.reg_file.registers[1], dut.dmem.memory[0]);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (pc !== 64'd0 || dut.reg_file.registers[1] !== 64'd0 ||
        dut.reg_file.registers[2] !== 64'd0 ||
        dut.dmem.memory[0] !== 64'd0) begin
      fails++;
      $display("FAIL mid_async pc=%0d x1=%0d x2=%0d m0=%0d want 0",
               pc, dut.reg_file.registers[1],
               dut.reg_file.registers[2], dut.dmem.memory[0]);
    end
    @(negedge clk);
    tests++;
    if (pc !== 64'd0) begin
      fails++; $display("FAIL mid_held got %0d want 0", pc);
    end
    #1;
    reset = 1'b1;
    step(3);
    tests++;
    if (pc !== 64'd12 || dut.reg_file.registers[2] !== 64'd9 ||
        dut.reg_file.registers[1] !== 64'd1) begin
      fails++;
      $display("FAIL mid_restart pc=%0d x2=%0d x1=%0d want 12/9/1",
               pc, dut.reg_file.registers[2], dut.reg_file.registers[1]);
    end
  endtask

  task automatic test_unsupported();
    int nz;
    clear_prog();
    prog[0] = addi(5'd1, 5'd0, 12'd7);
    prog[1] = 32'h0000006F;
    prog[2] = rtype(7'b0000000, 3'b001, 5'd10, 5'd1, 5'd1);
    boot();
    step(2);
    tests++;
    if (pc !== 64'd8 || dut.reg_file.registers[1] !== 64'd7) begin
      fails++;
      $display("FAIL nop_jal pc=%0d x1=%0d want 8/7",
               pc, dut.reg_file.registers[1]);
    end
    step(1);
    nz = 0;
    for (int i = 2; i < 32; i++)
      if (dut.reg_file.registers[i] !== 64'd0) nz++;
    for (int i = 0; i < 32; i++)
      if (dut.dmem.memory[i] !== 64'd0) nz++;
    tests++;
    if (nz !== 0) begin
      fails++; $display("FAIL nop_state nonzero %0d want 0", nz);
    end
    tests++;
    if (pc !== 64'd12 || halted !== 1'b1) begin
      fails++;
      $display("FAIL nop_pc pc=%0d halted=%0b want 12/1", pc, halted);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    clear_prog();
    test_reset();
    test_program();
    test_alu();
    test_load_x0();
    test_branch(12'd5, 1'b1);
    test_branch(12'd6, 1'b0);
    test_branch_loops();
    test_reset_mid();
    test_unsupported();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
